// File: rtl/display_ctrl_if.sv
// Display controller bus: stopwatch field values and adjust controls in, multiplexed
// seven-segment drive out.
interface display_ctrl_if;
  logic [5:0] mincounter;
  logic [5:0] seccounter;
  logic       adj;
  logic       sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output mincounter, seccounter, adj, sel,
    input  an, seg, dp
  );

  modport slave (
    input  mincounter, seccounter, adj, sel,
    output an, seg, dp
  );
endinterface

// File: rtl/display_ctrl.sv
// Four-digit multiplexed MM:SS seven-segment driver with blinking of the field being
// adjusted. All outputs are active low and registered.
module display_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic          clk,
  input  logic          btn0_val,
  display_ctrl_if.slave bus
);

  localparam int unsigned RefW   = $clog2(REFRESH_DIV);
  localparam int unsigned BlinkW = $clog2(BLINK_DIV);

  localparam logic [RefW-1:0]   RefMax   = RefW'(REFRESH_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_DIV - 1);

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegDash  = 7'b0111111;

  // Bit order {g,f,e,d,c,b,a}, active low; anything that is not a decimal digit shows dash.
  function automatic logic [6:0] seg_digit(input logic [5:0] d);
    logic [6:0] s;
    case (d)
      6'd0:    s = 7'b1000000;
      6'd1:    s = 7'b1111001;
      6'd2:    s = 7'b0100100;
      6'd3:    s = 7'b0110000;
      6'd4:    s = 7'b0011001;
      6'd5:    s = 7'b0010010;
      6'd6:    s = 7'b0000010;
      6'd7:    s = 7'b1111000;
      6'd8:    s = 7'b0000000;
      6'd9:    s = 7'b0010000;
      default: s = SegDash;
    endcase
    return s;
  endfunction

  logic [RefW-1:0]   ref_cnt_q;
  logic [1:0]        digit_idx_q;
  logic [BlinkW-1:0] blink_cnt_q;
  logic              blink_phase_q;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic       tick;
  logic [1:0] digit_nxt;
  logic [5:0] field;
  logic [5:0] tens;
  logic [5:0] ones;
  logic [5:0] digit_val;
  logic       blank;

  assign tick      = (ref_cnt_q == RefMax);
  assign digit_nxt = digit_idx_q + 2'd1;

  // Output image for the digit that becomes active at the coming tick.
  always_comb begin
    field     = digit_nxt[1] ? bus.mincounter : bus.seccounter;
    tens      = field / 6'd10;
    ones      = field % 6'd10;
    digit_val = digit_nxt[0] ? tens : ones;
    // Digits 0,1 belong to seconds (sel=1), digits 2,3 to minutes (sel=0).
    blank     = bus.adj & blink_phase_q & (bus.sel ^ digit_nxt[1]);

    an_d  = 4'b1111;
    seg_d = SegBlank;
    dp_d  = 1'b1;
    if (!blank) begin
      an_d  = ~(4'b0001 << digit_nxt);
      seg_d = (field > 6'd59) ? SegDash : seg_digit(digit_val);
      dp_d  = (digit_nxt != 2'd2);
    end
  end

  always_ff @(posedge clk or posedge btn0_val) begin
    if (btn0_val) begin
      ref_cnt_q     <= '0;
      digit_idx_q   <= 2'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      an_q          <= 4'b1111;
      seg_q         <= SegBlank;
      dp_q          <= 1'b1;
    end else begin
      ref_cnt_q <= tick ? '0 : ref_cnt_q + RefW'(1);

      if (tick) begin
        digit_idx_q <= digit_nxt;
        an_q        <= an_d;
        seg_q       <= seg_d;
        dp_q        <= dp_d;
      end

      // Leaving adjust mode restarts the blink so re-entry always begins visible.
      if (!bus.adj) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= 1'b0;
      end else if (blink_cnt_q == BlinkMax) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BlinkW'(1);
      end
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

  // At most one anode may be driven, and the separator only lights with digit 2.
  a_an_onehot: assert property (@(posedge clk) disable iff (btn0_val)
    $countones(~an_q) <= 1);
  a_dp_digit2: assert property (@(posedge clk) disable iff (btn0_val)
    !dp_q |-> (an_q == 4'b1011));

endmodule
